// File: rtl/imm_inst_encoder.sv
// imm_inst_encoder: packs RV32I fields and a signed immediate into an instruction word behind
// one valid/ready output register with a running write address. Optional range checking: `IMM_RANGE_CHECK_EN.
module imm_inst_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        sl,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_sticky
);

  localparam logic [2:0] SL_I = 3'b000;
  localparam logic [2:0] SL_S = 3'b001;
  localparam logic [2:0] SL_B = 3'b010;
  localparam logic [2:0] SL_J = 3'b011;
  localparam logic [2:0] SL_U = 3'b100;
  localparam logic [2:0] SL_R = 3'b101;

  localparam logic [31:0]       NOP       = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP);

  logic [31:0] enc_word;
  logic        emit;
  logic        accept;
  logic        deliver;

  // Bit placement mirrors the immediate extender exactly, so extend(encode(x)) == x.
  always_comb begin
    enc_word = NOP;
    case (sl)
      SL_I:    enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      SL_S:    enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      SL_B:    enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      SL_J:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      SL_U:    enc_word = {imm[31:12], rd, opcode};
      SL_R:    enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      default: enc_word = NOP;
    endcase
  end

  assign in_ready = !restart && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               range_bad;
  logic               err_q;

  assign simm = $signed(imm);

  always_comb begin
    range_bad = 1'b0;
    case (sl)
      SL_I, SL_S: range_bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      SL_B:       range_bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      SL_J:       range_bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      SL_U:       range_bad = (imm[11:0] != 12'd0);
      SL_R:       range_bad = 1'b0;
      default:    range_bad = 1'b1;
    endcase
  end

  assign emit = !range_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (restart) begin
      err_q <= 1'b0;
    end else if (accept && range_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err_sticky = err_q;
`else
  assign emit       = 1'b1;
  assign err_sticky = 1'b0;
`endif

  // A rejected word still consumes its input handshake but never reaches the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_inst  <= 32'd0;
      out_addr  <= ADDR_BASE;
    end else if (restart) begin
      out_valid <= 1'b0;
      out_addr  <= ADDR_BASE;
    end else begin
      if (deliver) begin
        out_addr <= out_addr + ADDR_INC;
      end
      if (accept && emit) begin
        out_valid <= 1'b1;
        out_inst  <= enc_word;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Bench for imm_inst_encoder: directed vectors, a field-arithmetic model with a delivery scoreboard,
// and literal checks; a second instance with ADDR_W=4 exercises address wrap.
module tb_imm_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, restart, in_valid, out_ready;
  logic [2:0]  sl;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;

  logic        in_ready, out_valid, err_sticky;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;
  logic        rdy4, v4, err4;
  logic [31:0] inst4;
  logic [3:0]  addr4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_inst_encoder dut (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .sl(sl), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .err_sticky(err_sticky)
  );

  imm_inst_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(rdy4),
    .sl(sl), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .out_valid(v4), .out_ready(out_ready),
    .out_inst(inst4), .out_addr(addr4), .err_sticky(err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding model built from the field layout with shifts and masks.
  function automatic logic [31:0] model_enc(input logic [2:0] s, input logic [6:0] op,
      input logic [4:0] d, input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
      input logic [6:0] f7, input logic [31:0] im, output bit bad);
    longint v;
    logic [31:0] w;
    v = longint'($signed(im));
    bad = 1'b0;
    case (s)
      3'd0: begin
        w = ((im & 32'hFFF) << 20) | (32'(r1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
        bad = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        w = (((im >> 5) & 32'h7F) << 25) | (32'(r2) << 20) | (32'(r1) << 15) | (32'(f3) << 12)
          | ((im & 32'h1F) << 7) | 32'(op);
        bad = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(r2) << 20)
          | (32'(r1) << 15) | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8)
          | (((im >> 11) & 32'h1) << 7) | 32'(op);
        bad = (v < -4096) || (v > 4094) || (im[0] == 1'b1);
      end
      3'd3: begin
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
          | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
        bad = (v < -1048576) || (v > 1048574) || (im[0] == 1'b1);
      end
      3'd4: begin
        w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
        bad = (im & 32'hFFF) != 32'd0;
      end
      3'd5: begin
        w = (32'(f7) << 25) | (32'(r2) << 20) | (32'(r1) << 15) | (32'(f3) << 12)
          | (32'(d) << 7) | 32'(op);
      end
      default: begin
        w = 32'h00000013;
        bad = 1'b1;
      end
    endcase
    return w;
  endfunction

  // Scoreboard: pending words, expected addresses for both instances, expected sticky error.
  logic [31:0] q[$];
  int          ea10, ea4;
  bit          eerr;
  logic [31:0] got_inst[$];
  int          got_addr[$];
  int          got_a4[$];

  always @(posedge clk) begin
    bit          bad, rdy, emit;
    logic [31:0] w;
    rdy = !restart && (q.size() == 0 || out_ready);
    if (rst) begin
      q.delete();
      ea10 = 0; ea4 = 0; eerr = 1'b0;
    end else if (restart) begin
      q.delete();
      ea10 = 0; ea4 = 0; eerr = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        got_inst.push_back(out_inst);
        got_addr.push_back(int'(out_addr));
        got_a4.push_back(int'(addr4));
      end
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        ea10 = (ea10 + 4) % 1024;
        ea4  = (ea4 + 4) % 16;
      end
      if (in_valid && rdy) begin
        w = model_enc(sl, opcode, rd, funct3, rs1, rs2, funct7, imm, bad);
`ifdef IMM_RANGE_CHECK_EN
        emit = !bad;
`else
        emit = 1'b1;
`endif
        if (emit) q.push_back(w);
        else eerr = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_valid4", 32'(v4), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(!restart && (q.size() == 0 || out_ready)));
      chk("in_ready4", 32'(rdy4), 32'(!restart && (q.size() == 0 || out_ready)));
      chk("out_addr", 32'(out_addr), 32'(ea10));
      chk("out_addr4", 32'(addr4), 32'(ea4));
      chk("err_sticky", 32'(err_sticky), 32'(eerr));
      chk("err_sticky4", 32'(err4), 32'(eerr));
      if (q.size() != 0) begin
        chk("out_inst", out_inst, q[0]);
        chk("out_inst4", inst4, q[0]);
      end
    end
  end

  task automatic send(input logic [2:0] s, input logic [6:0] op, input logic [4:0] d,
      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
      input logic [6:0] f7, input logic [31:0] im);
    int n;
    sl = s; opcode = op; rd = d; funct3 = f3; rs1 = r1; rs2 = r2; funct7 = f7; imm = im;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int idx, input logic [31:0] inst, input int a10, input int a4);
    if (idx >= got_inst.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d words delivered, index %0d required", name, got_inst.size(), idx);
    end else begin
      chk({name, "_inst"}, got_inst[idx], inst);
      chk({name, "_addr"}, 32'(got_addr[idx]), 32'(a10));
      chk({name, "_addr4"}, 32'(got_a4[idx]), 32'(a4));
    end
  endtask

  initial begin
    bit b;
    rst = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sl = 3'd0; opcode = 7'd0; rd = 5'd0; funct3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct7 = 7'd0; imm = 32'd0;

    chk("model_I", model_enc(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF, b), 32'hFFF00093);
    chk("model_S", model_enc(3'd1, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 7'd0, 32'd8, b), 32'h0021A423);
    chk("model_B", model_enc(3'd2, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFC, b), 32'hFE000EE3);
    chk("model_J", model_enc(3'd3, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, b), 32'h001000EF);
    chk("model_U", model_enc(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, b), 32'h123452B7);
    chk("model_I_range_bad", 32'(b), 32'd0);
    void'(model_enc(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, b));
    chk("model_I_2048_bad", 32'(b), 32'd1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_inst", out_inst, 32'd0);
    chk("reset_addr", 32'(out_addr), 32'd0);
    chk("reset_err", 32'(err_sticky), 32'd0);

    out_ready = 1'b1;
    send(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFF);
    idle(2);
    restart = 1'b1;
    idle(1);
    restart = 1'b0;

    send(3'd1, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 7'd0, 32'd8);
    send(3'd2, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFC);
    send(3'd3, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    send(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
    idle(2);

    out_ready = 1'b0;
    send(3'd5, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'hDEADBEEF);
    fork
      send(3'd0, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(2);

    send(3'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    idle(2);
`ifdef IMM_RANGE_CHECK_EN
    chk("range_err", 32'(err_sticky), 32'd1);
`endif
    send(3'd6, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    idle(2);

    lit("I", 0, 32'hFFF00093, 0, 0);
    lit("S", 1, 32'h0021A423, 0, 0);
    lit("B", 2, 32'hFE000EE3, 4, 4);
    lit("J", 3, 32'h001000EF, 8, 8);
    lit("U", 4, 32'h123452B7, 12, 12);
    lit("R_wrap", 5, 32'h402081B3, 16, 0);
    lit("I_after_stall", 6, 32'h00500113, 20, 4);
`ifdef IMM_RANGE_CHECK_EN
    chk("range_dropped", 32'(got_inst.size()), 32'd7);
`else
    lit("I_trunc", 7, 32'h80000093, 24, 8);
    lit("illegal_nop", 8, 32'h00000013, 28, 12);
`endif

    out_ready = 1'b0;
    send(3'd4, 7'h37, 5'd6, 3'd0, 5'd0, 5'd0, 7'd0, 32'hABCDE000);
    restart = 1'b1;
    sl = 3'd0; imm = 32'd1; in_valid = 1'b1;
    #1;
    chk("restart_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 restart = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("restart_valid", 32'(out_valid), 32'd0);
    chk("restart_addr", 32'(out_addr), 32'd0);
    chk("restart_err", 32'(err_sticky), 32'd0);
    out_ready = 1'b1;
    send(3'd3, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    idle(2);
    if (got_inst.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL post_restart: no words delivered");
    end else begin
      chk("post_restart_inst", got_inst[got_inst.size()-1], 32'h001000EF);
      chk("post_restart_addr", 32'(got_addr[got_addr.size()-1]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, %0d checks so far", checks);
    $fatal(1, "timeout");
  end

endmodule
